// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
// Execute stage of the five-stage pipeline. It selects the ALU operands from
// the ID/EX bundle, evaluates the ALU and captures the result, the store data
// and the pass-through control bits in the EX/MEM pipeline register.
// The hazard logic can hold the register (stall) or load a bubble (flush).
//
// Ports
//   clock, reset                     rising-edge clock, synchronous active-high reset
//   ex_shiftAmount                   zero-extended shamt (operand A alternative)
//   ex_immediate                     extended immediate (operand B alternative)
//   ex_registerRsOrPc_4              operand A source
//   ex_registerRtOrZero              operand B source and store data
//   ex_aluOperation                  ALU op code (4 bits)
//   ex_shouldAluUse*                 operand A / operand B selects
//   ex_shouldWrite*, ex_registerWriteAddress   control passed to MEM
//   ex_stall, ex_flush               hazard controls (stall wins over flush)
//   ex_aluOutput                     combinational ALU result for forwarding
//   mem_*                            EX/MEM pipeline register contents
//   mem_valid                        1 = real instruction, 0 = bubble
// -----------------------------------------------------------------------------
module execute_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ex_shiftAmount,
  input  logic [31:0] ex_immediate,
  input  logic [31:0] ex_registerRsOrPc_4,
  input  logic [31:0] ex_registerRtOrZero,
  input  logic [3:0]  ex_aluOperation,
  input  logic        ex_shouldAluUseShiftAmountElseRegisterRsOrPc_4,
  input  logic        ex_shouldAluUseImmeidateElseRegisterRtOrZero,
  input  logic        ex_shouldWriteRegister,
  input  logic        ex_shouldWriteMemoryElseAluOutputToRegister,
  input  logic        ex_shouldWriteMemory,
  input  logic [4:0]  ex_registerWriteAddress,
  input  logic        ex_stall,
  input  logic        ex_flush,
  output logic [31:0] ex_aluOutput,
  output logic [31:0] mem_aluOutput,
  output logic [31:0] mem_registerRtOrZero,
  output logic        mem_shouldWriteRegister,
  output logic        mem_shouldWriteMemoryElseAluOutputToRegister,
  output logic        mem_shouldWriteMemory,
  output logic [4:0]  mem_registerWriteAddress,
  output logic        mem_valid
);

  logic [31:0] operandA_s;
  logic [31:0] operandB_s;
  logic [4:0]  shiftAmount_s;
  logic [31:0] aluResult_s;

  logic [31:0] memAluOutput_r;
  logic [31:0] memRegisterRtOrZero_r;
  logic        memShouldWriteRegister_r;
  logic        memShouldWriteMemoryElseAluOutputToRegister_r;
  logic        memShouldWriteMemory_r;
  logic [4:0]  memRegisterWriteAddress_r;
  logic        memValid_r;

  // Operand selection for the ALU.
  always_comb begin
    operandA_s = ex_registerRsOrPc_4;
    operandB_s = ex_registerRtOrZero;
    if (ex_shouldAluUseShiftAmountElseRegisterRsOrPc_4) begin
      operandA_s = ex_shiftAmount;
    end else begin
      operandA_s = ex_registerRsOrPc_4;
    end
    if (ex_shouldAluUseImmeidateElseRegisterRtOrZero) begin
      operandB_s = ex_immediate;
    end else begin
      operandB_s = ex_registerRtOrZero;
    end
  end

  // Shifts honour only the low five bits of operand A.
  assign shiftAmount_s = operandA_s[4:0];

  // ALU evaluation; ADD/SUB wrap silently, unused op codes yield zero.
  always_comb begin
    aluResult_s = 32'd0;
    case (ex_aluOperation)
      4'd0:    aluResult_s = operandA_s + operandB_s;
      4'd1:    aluResult_s = operandA_s - operandB_s;
      4'd2:    aluResult_s = operandA_s & operandB_s;
      4'd3:    aluResult_s = operandA_s | operandB_s;
      4'd4:    aluResult_s = operandA_s ^ operandB_s;
      4'd5:    aluResult_s = ~(operandA_s | operandB_s);
      4'd6:    aluResult_s = ($signed(operandA_s) < $signed(operandB_s)) ? 32'd1 : 32'd0;
      4'd7:    aluResult_s = (operandA_s < operandB_s) ? 32'd1 : 32'd0;
      4'd8:    aluResult_s = operandB_s << shiftAmount_s;
      4'd9:    aluResult_s = operandB_s >> shiftAmount_s;
      4'd10:   aluResult_s = $unsigned($signed(operandB_s) >>> shiftAmount_s);
      4'd11:   aluResult_s = {operandB_s[15:0], 16'h0000};
      default: aluResult_s = 32'd0;
    endcase
  end

  assign ex_aluOutput = aluResult_s;

  // EX/MEM pipeline register: reset > stall (hold) > flush (bubble) > load.
  always_ff @(posedge clock) begin
    if (reset) begin
      memAluOutput_r                                <= 32'd0;
      memRegisterRtOrZero_r                         <= 32'd0;
      memShouldWriteRegister_r                      <= 1'b0;
      memShouldWriteMemoryElseAluOutputToRegister_r <= 1'b0;
      memShouldWriteMemory_r                        <= 1'b0;
      memRegisterWriteAddress_r                     <= 5'd0;
      memValid_r                                    <= 1'b0;
    end else if (ex_stall) begin
      memAluOutput_r                                <= memAluOutput_r;
      memRegisterRtOrZero_r                         <= memRegisterRtOrZero_r;
      memShouldWriteRegister_r                      <= memShouldWriteRegister_r;
      memShouldWriteMemoryElseAluOutputToRegister_r <= memShouldWriteMemoryElseAluOutputToRegister_r;
      memShouldWriteMemory_r                        <= memShouldWriteMemory_r;
      memRegisterWriteAddress_r                     <= memRegisterWriteAddress_r;
      memValid_r                                    <= memValid_r;
    end else if (ex_flush) begin
      memAluOutput_r                                <= 32'd0;
      memRegisterRtOrZero_r                         <= 32'd0;
      memShouldWriteRegister_r                      <= 1'b0;
      memShouldWriteMemoryElseAluOutputToRegister_r <= 1'b0;
      memShouldWriteMemory_r                        <= 1'b0;
      memRegisterWriteAddress_r                     <= 5'd0;
      memValid_r                                    <= 1'b0;
    end else begin
      memAluOutput_r                                <= aluResult_s;
      memRegisterRtOrZero_r                         <= ex_registerRtOrZero;
      memShouldWriteRegister_r                      <= ex_shouldWriteRegister;
      memShouldWriteMemoryElseAluOutputToRegister_r <= ex_shouldWriteMemoryElseAluOutputToRegister;
      memShouldWriteMemory_r                        <= ex_shouldWriteMemory;
      memRegisterWriteAddress_r                     <= ex_registerWriteAddress;
      memValid_r                                    <= 1'b1;
    end
  end

  assign mem_aluOutput                                = memAluOutput_r;
  assign mem_registerRtOrZero                         = memRegisterRtOrZero_r;
  assign mem_shouldWriteRegister                      = memShouldWriteRegister_r;
  assign mem_shouldWriteMemoryElseAluOutputToRegister = memShouldWriteMemoryElseAluOutputToRegister_r;
  assign mem_shouldWriteMemory                        = memShouldWriteMemory_r;
  assign mem_registerWriteAddress                     = memRegisterWriteAddress_r;
  assign mem_valid                                    = memValid_r;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: a table of ALU vectors pushed through
// a scoreboard, plus hand-written reset, stall and flush sequences.
module tb_execute_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ex_shiftAmount, ex_immediate, ex_registerRsOrPc_4, ex_registerRtOrZero;
  logic [3:0]  ex_aluOperation;
  logic        ex_selA, ex_selB;
  logic        ex_wr, ex_m2r, ex_wm;
  logic [4:0]  ex_waddr;
  logic        ex_stall, ex_flush;
  logic [31:0] ex_aluOutput, mem_aluOutput, mem_registerRtOrZero;
  logic        mem_wr, mem_m2r, mem_wm;
  logic [4:0]  mem_waddr;
  logic        mem_valid;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  execute_stage dut (
    .clock(clock),
    .reset(reset),
    .ex_shiftAmount(ex_shiftAmount),
    .ex_immediate(ex_immediate),
    .ex_registerRsOrPc_4(ex_registerRsOrPc_4),
    .ex_registerRtOrZero(ex_registerRtOrZero),
    .ex_aluOperation(ex_aluOperation),
    .ex_shouldAluUseShiftAmountElseRegisterRsOrPc_4(ex_selA),
    .ex_shouldAluUseImmeidateElseRegisterRtOrZero(ex_selB),
    .ex_shouldWriteRegister(ex_wr),
    .ex_shouldWriteMemoryElseAluOutputToRegister(ex_m2r),
    .ex_shouldWriteMemory(ex_wm),
    .ex_registerWriteAddress(ex_waddr),
    .ex_stall(ex_stall),
    .ex_flush(ex_flush),
    .ex_aluOutput(ex_aluOutput),
    .mem_aluOutput(mem_aluOutput),
    .mem_registerRtOrZero(mem_registerRtOrZero),
    .mem_shouldWriteRegister(mem_wr),
    .mem_shouldWriteMemoryElseAluOutputToRegister(mem_m2r),
    .mem_shouldWriteMemory(mem_wm),
    .mem_registerWriteAddress(mem_waddr),
    .mem_valid(mem_valid)
  );

  typedef struct {
    string       name;
    logic [31:0] shamt, imm, rs, rt;
    logic [3:0]  op;
    logic        selA, selB, wr, m2r, wm;
    logic [4:0]  waddr;
    logic [31:0] expAlu;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] alu, rt;
    logic        wr, m2r, wm;
    logic [4:0]  waddr;
    logic        valid;
  } exp_t;

  vec_t vecs[16];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkMem(input string name, input logic [31:0] alu, input logic [31:0] rt,
                          input logic wr, input logic m2r, input logic wm,
                          input logic [4:0] waddr, input logic valid);
    check({name, ".alu"},   mem_aluOutput, alu);
    check({name, ".rt"},    mem_registerRtOrZero, rt);
    check({name, ".wr"},    {31'd0, mem_wr}, {31'd0, wr});
    check({name, ".m2r"},   {31'd0, mem_m2r}, {31'd0, m2r});
    check({name, ".wm"},    {31'd0, mem_wm}, {31'd0, wm});
    check({name, ".waddr"}, {27'd0, mem_waddr}, {27'd0, waddr});
    check({name, ".valid"}, {31'd0, mem_valid}, {31'd0, valid});
  endtask

  task automatic drive(input vec_t v);
    ex_shiftAmount      = v.shamt;
    ex_immediate        = v.imm;
    ex_registerRsOrPc_4 = v.rs;
    ex_registerRtOrZero = v.rt;
    ex_aluOperation     = v.op;
    ex_selA             = v.selA;
    ex_selB             = v.selB;
    ex_wr               = v.wr;
    ex_m2r              = v.m2r;
    ex_wm               = v.wm;
    ex_waddr            = v.waddr;
  endtask

  function automatic vec_t mk(input string n, input logic [31:0] shamt, input logic [31:0] imm,
                              input logic [31:0] rs, input logic [31:0] rt, input logic [3:0] op,
                              input logic selA, input logic selB, input logic wr, input logic m2r,
                              input logic wm, input logic [4:0] waddr, input logic [31:0] expAlu);
    vec_t v;
    v.name = n; v.shamt = shamt; v.imm = imm; v.rs = rs; v.rt = rt; v.op = op;
    v.selA = selA; v.selB = selB; v.wr = wr; v.m2r = m2r; v.wm = wm; v.waddr = waddr;
    v.expAlu = expAlu;
    return v;
  endfunction

  // Drive a vector, check the forwarding output, queue the expected register contents.
  task automatic issue(input vec_t v);
    exp_t e;
    drive(v);
    #1;
    check({v.name, ".fwd"}, ex_aluOutput, v.expAlu);
    e.name = v.name; e.alu = v.expAlu; e.rt = v.rt; e.wr = v.wr; e.m2r = v.m2r;
    e.wm = v.wm; e.waddr = v.waddr; e.valid = 1'b1;
    sb.push_back(e);
  endtask

  // Advance one edge and compare the register against the oldest queued expectation.
  task automatic retire();
    exp_t e;
    @(posedge clock);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      checks--;
      e = sb.pop_front();
      checkMem(e.name, e.alu, e.rt, e.wr, e.m2r, e.wm, e.waddr, e.valid);
    end
  endtask

  initial begin
    vecs[0]  = mk("add_wrap", 32'd0, 32'd0, 32'hFFFFFFFF, 32'd1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 32'h00000000);
    vecs[1]  = mk("sub_wrap", 32'd0, 32'd0, 32'h00000000, 32'd1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 32'hFFFFFFFF);
    vecs[2]  = mk("and", 32'd0, 32'd0, 32'hF0F0F0F0, 32'hFF00FF00, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 32'hF000F000);
    vecs[3]  = mk("or",  32'd0, 32'd0, 32'hF0F0F0F0, 32'hFF00FF00, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 32'hFFF0FFF0);
    vecs[4]  = mk("xor", 32'd0, 32'd0, 32'hF0F0F0F0, 32'hFF00FF00, 4'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 32'h0FF00FF0);
    vecs[5]  = mk("nor", 32'd0, 32'd0, 32'hF0F0F0F0, 32'hFF00FF00, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd6, 32'h000F000F);
    vecs[6]  = mk("slt", 32'd0, 32'd0, 32'hFFFFFFFF, 32'd1, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 32'd1);
    vecs[7]  = mk("sltu", 32'd0, 32'd0, 32'hFFFFFFFF, 32'd1, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd8, 32'd0);
    vecs[8]  = mk("srl", 32'd4, 32'd0, 32'h12345678, 32'h80000000, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 32'h08000000);
    vecs[9]  = mk("sra", 32'd4, 32'd0, 32'h12345678, 32'h80000000, 4'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd10, 32'hF8000000);
    vecs[10] = mk("sll_shamt5", 32'h24, 32'd0, 32'h0, 32'd1, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd11, 32'h00000010);
    vecs[11] = mk("lui", 32'd0, 32'h1234, 32'h0, 32'h55, 4'd11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd12, 32'h12340000);
    vecs[12] = mk("op12", 32'd0, 32'd0, 32'd5, 32'd6, 4'd12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd13, 32'd0);
    vecs[13] = mk("op15", 32'd0, 32'd0, 32'd5, 32'd6, 4'd15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd14, 32'd0);
    vecs[14] = mk("selA_add", 32'd3, 32'd0, 32'd100, 32'd2, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd15, 32'd5);
    vecs[15] = mk("store", 32'd0, 32'd8, 32'h1000, 32'hDEADBEEF, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h00001008);

    // Reset with nonzero inputs for two cycles.
    reset = 1'b1; ex_stall = 1'b0; ex_flush = 1'b0;
    drive(vecs[4]);
    repeat (2) @(posedge clock);
    #1;
    checkMem("reset", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    reset = 1'b0;

    // Table vectors issued back-to-back through the scoreboard.
    for (int i = 0; i < 16; i++) begin
      issue(vecs[i]);
      retire();
    end

    // Load 5 -> addr 7, then stall three cycles with changing inputs.
    issue(mk("ld5", 32'd0, 32'd0, 32'd2, 32'd3, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 32'd5));
    retire();
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(mk("chg", 32'd0, 32'd0, 32'(i * 10 + 20), 32'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'(i + 20), 32'd0));
      #1;
      check("stall.fwd", ex_aluOutput, 32'(i * 10 + 21));
      @(posedge clock);
      #1;
      checkMem("stall", 32'd5, 32'd3, 1'b1, 1'b0, 1'b0, 5'd7, 1'b0 | 1'b1);
    end

    // Flush after the stall: bubble.
    ex_stall = 1'b0; ex_flush = 1'b1;
    @(posedge clock);
    #1;
    checkMem("flush", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);

    // Load 10, then stall+flush together must hold.
    ex_flush = 1'b0;
    issue(mk("ld10", 32'd0, 32'd0, 32'd9, 32'd1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 32'd10));
    retire();
    ex_stall = 1'b1; ex_flush = 1'b1;
    drive(vecs[2]);
    @(posedge clock);
    #1;
    checkMem("stallflush", 32'd10, 32'd1, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1);

    // Released: load resumes immediately.
    ex_stall = 1'b0; ex_flush = 1'b0;
    issue(vecs[11]);
    retire();

    // Reset asserted while stalled clears the register.
    ex_stall = 1'b1; reset = 1'b1;
    @(posedge clock);
    #1;
    checkMem("reset_stall", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    reset = 1'b0; ex_stall = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
